// File: rtl/shadow_memory_copier_if.sv
// MemBridge bus between the CPU (master) and the shadow memory copier (slave).
// Write data, address and direction are sampled together with MemBridge_Load.
interface shadow_memory_copier_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) ();

  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] MemDataIn;
  logic [DATA_W-1:0] MemDataOut;
  logic              MemBridge_Load;
  logic              MemBridge_Direction;
  logic              Memory_Ack;

  modport master (
    output Addr,
    output MemDataIn,
    output MemBridge_Load,
    output MemBridge_Direction,
    input  MemDataOut,
    input  Memory_Ack
  );

  modport slave (
    input  Addr,
    input  MemDataIn,
    input  MemBridge_Load,
    input  MemBridge_Direction,
    output MemDataOut,
    output Memory_Ack
  );

endinterface

// File: rtl/shadow_memory_copier.sv
// Shadow RAM: copies a ROM window into RAM while holding the CPU in reset, then serves MemBridge.
// Optional write protection of the copied window is enabled by defining SHADOW_WRITE_PROTECT_EN.
module shadow_memory_copier #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned COPY_BASE  = 0,
  parameter int unsigned COPY_WORDS = 32768
) (
  input  logic                  CopyClock,
  input  logic                  Reset_n,
  shadow_memory_copier_if.slave bus,
  output logic [ADDR_W-1:0]     RomAddr,
  input  logic [DATA_W-1:0]     RomData,
  input  logic                  ReCopy,
  output logic                  ResetReq,
  output logic                  WriteFault
);

  localparam int unsigned        Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]  BaseAddr = ADDR_W'(COPY_BASE);
  localparam logic [ADDR_W-1:0]  LastCnt  = ADDR_W'(COPY_WORDS - 1);

  typedef enum logic [1:0] {
    StCopy,
    StDrain,
    StRun
  } state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] cntQ, cntD;
  logic              copyWrPendQ;
  logic [ADDR_W-1:0] copyWrAddrQ;
  logic              resetReqQ;
  logic              ackQ;
  logic [DATA_W-1:0] dataOutQ;

  logic [DATA_W-1:0] ram [Depth];

  logic busLoad;
  logic busWrite;
  logic busRead;
  logic writeBlocked;

  // Next-state logic for the copy sequencer.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StCopy: begin
        cntD = cntQ + 1'b1;
        if (cntQ == LastCnt) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        stateD = StRun;
      end
      StRun: begin
        if (ReCopy) begin
          stateD = StCopy;
          cntD   = '0;
        end
      end
      default: begin
        stateD = StCopy;
        cntD   = '0;
      end
    endcase
  end

  assign RomAddr = BaseAddr + cntQ;

  assign busLoad  = bus.MemBridge_Load && (stateQ == StRun);
  assign busWrite = busLoad && bus.MemBridge_Direction && !writeBlocked;
  assign busRead  = busLoad && !bus.MemBridge_Direction;

`ifdef SHADOW_WRITE_PROTECT_EN
  logic [ADDR_W-1:0] winOffset;
  logic              inWindow;
  logic              faultQ;

  // Window membership is tested on the wrapped offset so windows crossing the top still match.
  assign winOffset    = bus.Addr - BaseAddr;
  assign inWindow     = {1'b0, winOffset} < (ADDR_W + 1)'(COPY_WORDS);
  assign writeBlocked = inWindow;

  always_ff @(posedge CopyClock or negedge Reset_n) begin
    if (!Reset_n) begin
      faultQ <= 1'b0;
    end else begin
      faultQ <= busLoad && bus.MemBridge_Direction && inWindow;
    end
  end

  assign WriteFault = faultQ;
`else
  assign writeBlocked = 1'b0;
  assign WriteFault   = 1'b0;
`endif

  always_ff @(posedge CopyClock or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ      <= StCopy;
      cntQ        <= '0;
      copyWrPendQ <= 1'b0;
      copyWrAddrQ <= '0;
      resetReqQ   <= 1'b1;
      ackQ        <= 1'b0;
      dataOutQ    <= '0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      // ROM is synchronous: the word for RomAddr arrives next cycle, so the address is delayed.
      copyWrPendQ <= (stateQ == StCopy);
      copyWrAddrQ <= RomAddr;
      resetReqQ   <= (stateD != StRun);
      ackQ        <= busLoad;
      if (busRead) begin
        dataOutQ <= ram[bus.Addr];
      end
    end
  end

  // RAM has no reset; contents survive Reset_n and are only replaced by copy or bus writes.
  always_ff @(posedge CopyClock) begin
    if (copyWrPendQ) begin
      ram[copyWrAddrQ] <= RomData;
    end else if (busWrite) begin
      ram[bus.Addr] <= bus.MemDataIn;
    end
  end

  assign ResetReq       = resetReqQ;
  assign bus.Memory_Ack = ackQ;
  assign bus.MemDataOut = dataOutQ;

endmodule

// File: tb/tb_shadow_memory_copier.sv
// Randomized bench for shadow_memory_copier: two instances (plain window and wrapping window)
// checked against an array model of the shadow RAM.
module tb_shadow_memory_copier;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic clk;
  logic rst_n;

  shadow_memory_copier_if #(.DATA_W(DW), .ADDR_W(AW)) busA ();
  shadow_memory_copier_if #(.DATA_W(DW), .ADDR_W(AW)) busB ();

  logic [AW-1:0] romAddrA, romAddrB;
  logic [DW-1:0] romDataA, romDataB;
  logic          reCopyA, reCopyB;
  logic          resetReqA, resetReqB;
  logic          faultA, faultB;

  shadow_memory_copier #(
    .DATA_W(DW), .ADDR_W(AW), .COPY_BASE(32'h10), .COPY_WORDS(4)
  ) dutA (
    .CopyClock (clk),
    .Reset_n   (rst_n),
    .bus       (busA),
    .RomAddr   (romAddrA),
    .RomData   (romDataA),
    .ReCopy    (reCopyA),
    .ResetReq  (resetReqA),
    .WriteFault(faultA)
  );

  shadow_memory_copier #(
    .DATA_W(DW), .ADDR_W(AW), .COPY_BASE(32'hFE), .COPY_WORDS(4)
  ) dutB (
    .CopyClock (clk),
    .Reset_n   (rst_n),
    .bus       (busB),
    .RomAddr   (romAddrB),
    .RomData   (romDataB),
    .ReCopy    (reCopyB),
    .ResetReq  (resetReqB),
    .WriteFault(faultB)
  );

  // Synchronous ROM images: data = 0xA000 + address.
  always @(posedge clk) begin
    romDataA <= 16'hA000 + 16'(romAddrA);
    romDataB <= 16'hA000 + 16'(romAddrB);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  logic [15:0] refA [256];
  logic [15:0] refB [256];
  bit          knownA [256];
  bit          knownB [256];
  logic [15:0] expOutA;
  bit          expOutKnownA;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit inWin(input int base, input int a);
    return ((a + 256 - base) % 256) < 4;
  endfunction

  function automatic bit protA(input logic [7:0] a);
`ifdef SHADOW_WRITE_PROTECT_EN
    return inWin(32'h10, int'(a));
`else
    return (a != a);
`endif
  endfunction

  function automatic bit protB(input logic [7:0] a);
`ifdef SHADOW_WRITE_PROTECT_EN
    return inWin(32'hFE, int'(a));
`else
    return (a != a);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleA();
    busA.MemBridge_Load      = 1'b0;
    busA.MemBridge_Direction = 1'b0;
    busA.Addr                = '0;
    busA.MemDataIn           = '0;
    reCopyA                  = 1'b0;
  endtask

  task automatic idleB();
    busB.MemBridge_Load      = 1'b0;
    busB.MemBridge_Direction = 1'b0;
    busB.Addr                = '0;
    busB.MemDataIn           = '0;
    reCopyB                  = 1'b0;
  endtask

  // One transaction on A, with its outcome checked in the cycle after the edge.
  task automatic opA(input bit wr, input logic [7:0] a, input logic [15:0] d, input bit rc);
    busA.MemBridge_Load      = 1'b1;
    busA.MemBridge_Direction = wr;
    busA.Addr                = a;
    busA.MemDataIn           = d;
    reCopyA                  = rc;
    tick();
    checkEq("ack A", 32'(busA.Memory_Ack), 1);
    if (wr) begin
      checkEq("write fault A", 32'(faultA), 32'(protA(a)));
      if (expOutKnownA) checkEq("out hold on write A", 32'(busA.MemDataOut), 32'(expOutA));
      if (!protA(a)) begin
        refA[a]   = d;
        knownA[a] = 1'b1;
      end
    end else begin
      checkEq("read fault A", 32'(faultA), 0);
      expOutKnownA = knownA[a];
      expOutA      = refA[a];
      if (knownA[a]) checkEq("read data A", 32'(busA.MemDataOut), 32'(refA[a]));
    end
    idleA();
  endtask

  // Checks a full copy starting in the current (first COPY) cycle; optional noise on A.
  task automatic copyCheck(input bit withB, input bit noise);
    for (int i = 0; i < 5; i++) begin
      checkEq("copy ResetReq A", 32'(resetReqA), 1);
      if (i > 0) checkEq("copy no ack A", 32'(busA.Memory_Ack), 0);
      if (i < 4) checkEq("copy RomAddr A", 32'(romAddrA), 32'((16 + i) % 256));
      if (withB) begin
        checkEq("copy ResetReq B", 32'(resetReqB), 1);
        if (i < 4) checkEq("copy RomAddr B", 32'(romAddrB), 32'((254 + i) % 256));
      end
      if (noise && i == 1) begin
        busA.MemBridge_Load      = 1'b1;
        busA.MemBridge_Direction = 1'b1;
        busA.Addr                = 8'h40;
        busA.MemDataIn           = 16'hDEAD;
        reCopyA                  = 1'b1;
      end else begin
        idleA();
      end
      tick();
    end
    checkEq("copy done ResetReq A", 32'(resetReqA), 0);
    if (withB) checkEq("copy done ResetReq B", 32'(resetReqB), 0);
    for (int i = 0; i < 4; i++) begin
      refA[(16 + i) % 256]   = 16'(32'hA000 + (16 + i) % 256);
      knownA[(16 + i) % 256] = 1'b1;
      if (withB) begin
        refB[(254 + i) % 256]   = 16'(32'hA000 + (254 + i) % 256);
        knownB[(254 + i) % 256] = 1'b1;
      end
    end
  endtask

  initial begin
    bit          doLoad;
    logic [7:0]  ra;
    rst_n        = 1'b0;
    idleA();
    idleB();
    expOutA      = '0;
    expOutKnownA = 1'b1;

    // Reset values.
    tick();
    tick();
    checkEq("reset ResetReq A", 32'(resetReqA), 1);
    checkEq("reset ack A", 32'(busA.Memory_Ack), 0);
    checkEq("reset MemDataOut A", 32'(busA.MemDataOut), 0);
    checkEq("reset RomAddr A", 32'(romAddrA), 32'h10);
    checkEq("reset RomAddr B", 32'(romAddrB), 32'hFE);
    checkEq("reset fault A", 32'(faultA), 0);
    tick();

    // Copy after reset on both instances; B's window wraps through 0x00.
    rst_n = 1'b1;
    copyCheck(1'b1, 1'b0);
    for (int i = 16; i < 20; i++) opA(1'b0, 8'(i), 16'h0, 1'b0);

    // Back-to-back write then read, then an idle cycle.
    opA(1'b1, 8'h40, 16'h1234, 1'b0);
    opA(1'b0, 8'h40, 16'h0, 1'b0);
    checkEq("b2b read data", 32'(busA.MemDataOut), 32'h1234);
    tick();
    checkEq("idle ack A", 32'(busA.Memory_Ack), 0);
    checkEq("idle hold A", 32'(busA.MemDataOut), 32'h1234);

    // Randomized traffic over the window edges and a scratch region.
    for (int n = 0; n < 150; n++) begin
      doLoad = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) ra = 8'(32'h0E + $urandom_range(0, 7));
      else ra = 8'(32'h40 + $urandom_range(0, 7));
      if (doLoad) begin
        opA(1'($urandom_range(0, 1)), ra, 16'($urandom), 1'b0);
      end else begin
        tick();
        checkEq("rand idle ack A", 32'(busA.Memory_Ack), 0);
        checkEq("rand idle fault A", 32'(faultA), 0);
        if (expOutKnownA) checkEq("rand hold A", 32'(busA.MemDataOut), 32'(expOutA));
      end
    end

    // Wrapped window on B: write into it, read back, and read the other wrapped words.
    busB.MemBridge_Load      = 1'b1;
    busB.MemBridge_Direction = 1'b1;
    busB.Addr                = 8'h00;
    busB.MemDataIn           = 16'hBEEF;
    tick();
    checkEq("B write ack", 32'(busB.Memory_Ack), 1);
    checkEq("B write fault", 32'(faultB), 32'(protB(8'h00)));
    if (!protB(8'h00)) refB[0] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      busB.MemBridge_Direction = 1'b0;
      busB.Addr                = 8'((254 + i) % 256);
      tick();
      checkEq("B read ack", 32'(busB.Memory_Ack), 1);
      checkEq("B read fault", 32'(faultB), 0);
      checkEq("B read data", 32'(busB.MemDataOut), 32'(refB[(254 + i) % 256]));
    end
    idleB();
    tick();
    checkEq("B idle ack", 32'(busB.Memory_Ack), 0);

    // ReCopy restores the window; a Load in the same cycle still completes.
    opA(1'b1, 8'h11, 16'h5555, 1'b0);
    opA(1'b0, 8'h11, 16'h0, 1'b0);
    opA(1'b0, 8'h40, 16'h0, 1'b1);
    copyCheck(1'b0, 1'b1);
    opA(1'b0, 8'h11, 16'h0, 1'b0);
    checkEq("recopy restored 0x11", 32'(busA.MemDataOut), 32'hA011);
    opA(1'b0, 8'h40, 16'h0, 1'b0);

    // Asynchronous reset in RUN, right after an ack.
    opA(1'b1, 8'h42, 16'h7777, 1'b0);
    rst_n = 1'b0;
    #1;
    checkEq("async rst ack", 32'(busA.Memory_Ack), 0);
    checkEq("async rst ResetReq A", 32'(resetReqA), 1);
    checkEq("async rst ResetReq B", 32'(resetReqB), 1);
    checkEq("async rst MemDataOut", 32'(busA.MemDataOut), 0);
    checkEq("async rst fault", 32'(faultA), 0);
    expOutA      = '0;
    expOutKnownA = 1'b1;
    tick();
    rst_n = 1'b1;
    copyCheck(1'b1, 1'b0);

    // Reset asserted with cnt=2 aborts the copy; it restarts from the base.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkEq("midcopy RomAddr", 32'(romAddrA), 32'h12);
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("midcopy rst ResetReq", 32'(resetReqA), 1);
    checkEq("midcopy rst ack", 32'(busA.Memory_Ack), 0);
    checkEq("midcopy rst RomAddr", 32'(romAddrA), 32'h10);
    tick();
    rst_n = 1'b1;
    copyCheck(1'b1, 1'b0);

    // RAM content survives reset and re-copy.
    for (int i = 16; i < 20; i++) opA(1'b0, 8'(i), 16'h0, 1'b0);
    opA(1'b0, 8'h42, 16'h0, 1'b0);
    checkEq("retained 0x42", 32'(busA.MemDataOut), 32'h7777);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/shadow_memory_copier.md
Name: shadow_memory_copier

Overview:
- Parametrised shadow-RAM block for the pipelined CPU.
- After reset, or on request, it copies a ROM image window into internal RAM while holding the CPU in reset through ResetReq.
- Once the copy completes, it serves MemBridge read/write transactions from the RAM with a one-cycle acknowledge.
- Successor to the fixed 64K shadow memory: configurable width and depth, configurable copy window, re-copy on demand, optional write protection.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width; RAM depth is 2^ADDR_W words.
- COPY_BASE, 0, first word address of the shadowed window. Same address is used in ROM and RAM.
- COPY_WORDS, 32768, number of words copied; 1..2^ADDR_W.

Ports:
- CopyClock  in  1  single clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Addr  in  ADDR_W  bus address, sampled when MemBridge_Load=1.
- MemDataIn  in  DATA_W  write data, sampled with MemBridge_Load.
- MemDataOut  out  DATA_W  read data, valid while Memory_Ack=1 on a read.
- MemBridge_Load  in  1  one-cycle transaction request.
- MemBridge_Direction  in  1  1 = write, 0 = read; sampled with Load.
- Memory_Ack  out  1  one-cycle completion pulse.
- RomAddr  out  ADDR_W  ROM address during copy.
- RomData  in  DATA_W  ROM data; valid one cycle after RomAddr (synchronous ROM).
- ReCopy  in  1  pulse requesting a new copy; honoured only in RUN.
- ResetReq  out  1  holds the CPU in reset while high.
- WriteFault  out  1  protected-write indication (see Optional Feature).

Behaviour:
- Reset (Reset_n=0, asynchronous) sets:
  - state=COPY, cnt=0, ResetReq=1, Memory_Ack=0, WriteFault=0, MemDataOut=0, RomAddr=COPY_BASE.
  - RAM contents are not cleared.
- States: COPY -> DRAIN -> RUN -> (ReCopy) COPY.
- COPY:
  - Each cycle, RomAddr = (COPY_BASE+cnt) mod 2^ADDR_W and a pending-write flag is registered.
  - One cycle later: RAM[(COPY_BASE+cnt_d) mod 2^ADDR_W] <= RomData.
  - cnt increments by 1 per cycle. When cnt = COPY_WORDS-1 has been issued, the next state is DRAIN.
- DRAIN: one cycle; performs the final RAM write, then moves to RUN.
- Copy duration: COPY_WORDS+1 cycles from the first COPY cycle to the first RUN cycle.
- ResetReq:
  - 1 throughout COPY and DRAIN.
  - Registered 0 on the edge that enters RUN, so it is low in the first RUN cycle.
- Window wrap: a window that runs past the top of the address space wraps modulo 2^ADDR_W.
- RUN transactions:
  - MemBridge_Load=1 at edge N samples Addr, Direction and MemDataIn.
  - Write: RAM updated at edge N.
  - Read: MemDataOut registered from RAM[Addr] at edge N.
  - Memory_Ack=1 for exactly the cycle after edge N.
  - Throughput is one transaction per cycle; back-to-back Loads give continuous Ack.
  - MemDataOut holds its last read value until the next read.
  - A read of an address written in the previous cycle returns the new data.
- Load during COPY/DRAIN: ignored; no Ack, no RAM change.
- ReCopy:
  - In RUN, ReCopy=1 moves to COPY with cnt=0; ResetReq=1 from the next cycle.
  - ReCopy and Load in the same RUN cycle: the transaction completes and acks normally, and the copy starts in the same edge.
  - ReCopy during COPY/DRAIN: ignored; the copy does not restart.
- Reset asserted mid-copy: the copy aborts and restarts from cnt=0 after release. RAM holds partial data until overwritten.

Optional Feature:
- Macro SHADOW_WRITE_PROTECT_EN.
- Defined:
  - In RUN, a write with Addr inside the window [COPY_BASE, COPY_BASE+COPY_WORDS) (modulo 2^ADDR_W) is discarded.
  - The write is still acked, and WriteFault=1 in the same cycle as Memory_Ack.
  - Reads and writes outside the window are unaffected.
  - Copy-engine writes are never blocked.
- Undefined: all writes are stored; WriteFault is tied 0.

Test Plan:
- Test parameters for all scenarios: ADDR_W=8, DATA_W=16, COPY_BASE=0x10, COPY_WORDS=4; ROM model returns data = 0xA000+addr.
- Copy after reset: release Reset_n -> RomAddr steps 0x10..0x13 on consecutive cycles; ResetReq high for exactly 5 cycles then low; reads of 0x10..0x13 return 0xA010..0xA013.
- Bus timing: write 0x1234 to 0x40, then read 0x40 on the following cycle -> Ack high in both following cycles; MemDataOut=0x1234 with the second Ack; Load during COPY gives no Ack.
- ReCopy: in RUN, write 0x5555 to 0x11, then pulse ReCopy -> ResetReq high for 5 cycles; read 0x11 returns 0xA011 (the macro-undefined build stores 0x5555 before the re-copy).
- Reset mid-copy: assert Reset_n=0 asynchronously when cnt=2 -> ResetReq=1 and Memory_Ack=0 immediately; after release, RomAddr restarts at 0x10 with a full 5-cycle copy.
- Wrap and protection: COPY_BASE=0xFE, COPY_WORDS=4 -> RomAddr sequence 0xFE, 0xFF, 0x00, 0x01. With SHADOW_WRITE_PROTECT_EN, a write of 0xBEEF to 0x00 -> Ack=1, WriteFault=1, and a read of 0x00 returns 0xA000.
